gen_buffer: RTL and testbench
=============================

GEN_BUFFER -- requirements
Module: gen_buffer

Interface
REQ-001 Parameter WIDTH, default 32, signed width of each tuple element.
REQ-002 Parameter DEPTH, default 4, number of tuple entries buffered (power of two, >=2).
REQ-003 Port _clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port _reset  input  1  asynchronous, active-high reset.
REQ-005 Port _start  input  1  one-cycle pulse; flushes the buffer and begins a new generator run.
REQ-006 Port _in_start  output  1  start pulse forwarded to the upstream generator.
REQ-007 Port _in_valid  input  1  upstream tuple valid.
REQ-008 Port _in_done  input  1  upstream generator exhausted (level).
REQ-009 Port _in0, _in1  input  WIDTH each  upstream tuple elements.
REQ-010 Port _in_ready  output  1  buffer accepts an upstream tuple this cycle.
REQ-011 Port _ready  input  1  downstream consumer ready.
REQ-012 Port _valid  output  1  _out0/_out1 hold a valid tuple.
REQ-013 Port _done  output  1  run finished and buffer empty.
REQ-014 Port _out0, _out1  output  WIDTH each  head-of-buffer tuple.

Function
REQ-015 Upstream transfer occurs on a cycle with _in_valid && _in_ready; downstream transfer on _valid && _ready.
REQ-016 States: DONE, RUN, DRAIN; the state register and count are the only control state.
REQ-017 DONE: _in_ready=0, _valid=0, _done=1; leaves only on _start.
REQ-018 _start in any state, next cycle: count=0, pointers=0, state=RUN, _done=0, _valid=0, _in_start=1 for exactly one cycle.
REQ-019 _start wins over a same-cycle upstream or downstream transfer; such transfers are discarded.
REQ-020 RUN: _in_ready = (count < DEPTH); in the cycle _in_start is high, _in_done is ignored (stale from previous run).
REQ-021 RUN with _in_done=1 (after the _in_start cycle): next state DRAIN; a tuple transferred in the same cycle is kept.
REQ-022 DRAIN: _in_ready=0; downstream pops continue; when count reaches 0, next state DONE.
REQ-023 Buffer is show-ahead: _valid = (count != 0); _out0/_out1 driven from the head entry register.
REQ-024 Latency: a tuple accepted at edge N is presented with _valid=1 after edge N, i.e. visible in cycle N+1; no combinational path _in_* -> _out*/_valid.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-026 Full (count=DEPTH): _in_ready=0; a pop the same cycle does not re-open _in_ready until the next cycle.
REQ-027 Empty: _valid=0; _ready ignored; no pointer movement.
REQ-028 Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-029 Data is stored and output bit-exact; no sign extension or arithmetic.
REQ-030 Tuple order on _out* equals upstream acceptance order.

Reset
REQ-031 _reset asserted: immediately state=DONE, count=0, pointers=0, _done=1, _valid=0, _in_ready=0, _in_start=0, _out0=_out1=0.
REQ-032 Reset mid-run discards buffered tuples; no output until the next _start.
REQ-033 _start while _reset is high has no effect.

Structure
REQ-034 Package gen_pkg holds the state enum type (DONE, RUN, DRAIN) and default WIDTH constant.
REQ-035 One sub-module, gen_buffer_mem: DEPTH x 2*WIDTH register array with write/read pointer ports; control FSM stays in gen_buffer.

Verification
REQ-036 Upstream hrange(1,11,3), _ready=1 constant -> _out0/_out1 pairs 1,4,7,10 in order, then _done=1, _valid=0.
REQ-037 Upstream hrange(0,10,2), _ready=0 for 10 cycles -> _in_ready drops after 4 accepts (0,2,4,6); releasing _ready yields 0,2,4,6,8 then _done.
REQ-038 Full buffer, _ready=1 for one cycle -> value 0 popped, count 3, _in_ready=1 next cycle, push of 8 accepted; order preserved.
REQ-039 _reset pulsed with 3 tuples buffered -> _valid=0, _done=1 immediately; subsequent _start re-runs hrange(0,10,2) from 0.
REQ-040 _start with _in_done still high from previous run -> _in_start pulses one cycle, state stays RUN, first new tuple 0 delivered.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared definitions for the generator tuple buffer: FSM state encoding and
// the default element width used by the interface and modules.
package gen_pkg;

  typedef enum logic [1:0] {
    DONE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } gen_state_e;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/gen_buffer_if.sv
// Handshake bundle between the upstream generator, the tuple buffer and the
// downstream consumer. The buffer takes the slave side; the driver of the run takes master.
interface gen_buffer_if import gen_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             _start;
  logic             _in_start;
  logic             _in_valid;
  logic             _in_done;
  logic [WIDTH-1:0] _in0;
  logic [WIDTH-1:0] _in1;
  logic             _in_ready;
  logic             _ready;
  logic             _valid;
  logic             _done;
  logic [WIDTH-1:0] _out0;
  logic [WIDTH-1:0] _out1;

  modport master (
    output _start, _in_valid, _in_done, _in0, _in1, _ready,
    input  _in_start, _in_ready, _valid, _done, _out0, _out1
  );

  modport slave (
    input  _start, _in_valid, _in_done, _in0, _in1, _ready,
    output _in_start, _in_ready, _valid, _done, _out0, _out1
  );

endinterface

// File: rtl/gen_buffer_mem.sv
// Tuple storage for the buffer: DEPTH entries of two packed elements, written at
// wr_ptr and read combinationally at rd_ptr so the head entry is always presented.
module gen_buffer_mem import gen_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [2*WIDTH-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [2*WIDTH-1:0]       rd_data
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  // Entries are cleared on reset so the head output reads zero until refilled.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/gen_buffer.sv
// Show-ahead tuple buffer between a restartable generator and its consumer.
// A run begins on _start, collects tuples until the generator reports done, then drains.
module gen_buffer import gen_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input logic         _clock,
  input logic         _reset,
  gen_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  gen_state_e         state;
  gen_state_e         state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               start_pulse;
  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  assign in_ready  = (state == RUN) && (count < FULL_COUNT);
  assign out_valid = (count != '0);

  // A start request flushes the buffer, so any transfer in that cycle is dropped.
  assign push = bus._in_valid && in_ready  && !bus._start;
  assign pop  = out_valid     && bus._ready && !bus._start;

  assign bus._in_ready = in_ready;
  assign bus._valid    = out_valid;
  assign bus._done     = (state == DONE);
  assign bus._in_start = start_pulse;
  assign bus._out0     = head[WIDTH-1:0];
  assign bus._out1     = head[2*WIDTH-1:WIDTH];

  gen_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    ._clock  (_clock),
    ._reset  (_reset),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({bus._in1, bus._in0}),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // During the _in_start cycle the generator still shows the previous run's done flag.
  always_comb begin
    state_next = state;
    count_next = count;
    if (bus._start) begin
      state_next = RUN;
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
      case (state)
        DONE:    state_next = DONE;
        RUN:     if (!start_pulse && bus._in_done) state_next = DRAIN;
        DRAIN:   if (count_next == '0) state_next = DONE;
        default: state_next = DONE;
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state       <= DONE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      start_pulse <= bus._start;
      if (bus._start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gen_buffer.sv
// Bench for gen_buffer: a cycle table for a plain hrange run, then hand sequences with
// a small range-generator model for back-pressure, full, restart and reset corner cases.
module tb_gen_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic tb_clock = 1'b0;
  logic tb_reset = 1'b1;

  gen_buffer_if #(.WIDTH(WIDTH)) bus ();

  gen_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    ._clock (tb_clock),
    ._reset (tb_reset),
    .bus    (bus)
  );

  always #5 tb_clock = ~tb_clock;

  typedef struct {
    logic              start;
    logic              in_valid;
    logic              in_done;
    logic              ready;
    logic signed [31:0] in0;
    logic signed [31:0] in1;
    logic              exp_in_ready;
    logic              exp_valid;
    logic              exp_done;
    logic              exp_in_start;
    logic signed [31:0] exp_out0;
    logic signed [31:0] exp_out1;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  vec_t vecs [9];

  int n_checks = 0;
  int n_errors = 0;

  // Upstream range generator: restarts on _in_start, advances on each accepted tuple.
  int gen_cur    = 0;
  int gen_first  = 0;
  int gen_stop   = 0;
  int gen_step   = 1;
  bit gen_active = 1'b0;
  bit start_req  = 1'b0;
  bit ready_req  = 1'b0;

  int exp_list[$];
  int exp_idx = 0;

  bit s_in_ready, s_valid, s_done, s_in_start, up_fire;
  int accepts;

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic applyStimulus();
    bit in_live;
    @(negedge tb_clock);
    in_live      = gen_active && (gen_cur < gen_stop);
    bus._start    = start_req;
    bus._ready    = ready_req;
    bus._in_valid = in_live;
    bus._in_done  = !in_live;
    bus._in0      = gen_cur;
    bus._in1      = -gen_cur;
    #1;
    s_in_ready = bus._in_ready;
    s_valid    = bus._valid;
    s_done     = bus._done;
    s_in_start = bus._in_start;
    up_fire    = in_live && s_in_ready && !start_req;
    if (s_valid && ready_req && !start_req) begin
      if (exp_idx < exp_list.size()) begin
        check_word($sformatf("pop%0d out0", exp_idx), bus._out0, exp_list[exp_idx]);
        check_word($sformatf("pop%0d out1", exp_idx), bus._out1, -exp_list[exp_idx]);
      end else begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL extra pop: got %0d, expected no tuple", $signed(bus._out0));
      end
      exp_idx++;
    end
    @(posedge tb_clock);
    if (s_in_start) begin
      gen_cur    = gen_first;
      gen_active = 1'b1;
    end else if (up_fire) begin
      gen_cur = gen_cur + gen_step;
    end
    #1;
  endtask

  task automatic set_run(int first, int stop, int step);
    gen_first = first;
    gen_stop  = stop;
    gen_step  = step;
    exp_idx   = 0;
  endtask

  task automatic do_start();
    start_req = 1'b1;
    applyStimulus();
    start_req  = 1'b0;
    gen_active = 1'b0;
  endtask

  task automatic checkOutput(int budget);
    int cycles = 0;
    ready_req = 1'b1;
    do begin
      applyStimulus();
      cycles++;
    end while (!s_done && cycles < budget);
    check_bit("drain reaches done", s_done, 1'b1);
    check_bit("valid low at done", s_valid, 1'b0);
    check_word("pop count", exp_idx, exp_list.size());
  endtask

  initial begin
    // hrange(1,11,3) with the consumer always ready; one tuple in flight at a time.
    vecs[0] = '{H, L, L, H,  0,   0,  L, L, H, L,  0,   0};
    vecs[1] = '{L, L, L, H,  0,   0,  H, L, L, H,  0,   0};
    vecs[2] = '{L, H, L, H,  1,  -1,  H, L, L, L,  0,   0};
    vecs[3] = '{L, H, L, H,  4,  -4,  H, H, L, L,  1,  -1};
    vecs[4] = '{L, H, L, H,  7,  -7,  H, H, L, L,  4,  -4};
    vecs[5] = '{L, H, L, H, 10, -10,  H, H, L, L,  7,  -7};
    vecs[6] = '{L, L, H, H,  0,   0,  H, H, L, L, 10, -10};
    vecs[7] = '{L, L, H, H,  0,   0,  L, L, L, L,  0,   0};
    vecs[8] = '{L, L, H, H,  0,   0,  L, L, H, L,  0,   0};

    bus._start = 1'b0; bus._ready = 1'b0; bus._in_valid = 1'b0;
    bus._in_done = 1'b0; bus._in0 = '0; bus._in1 = '0;
    repeat (2) @(posedge tb_clock);
    @(negedge tb_clock);
    #1;
    check_bit("reset in_ready", bus._in_ready, 1'b0);
    check_bit("reset valid", bus._valid, 1'b0);
    check_bit("reset done", bus._done, 1'b1);
    check_bit("reset in_start", bus._in_start, 1'b0);
    check_word("reset out0", bus._out0, 32'd0);
    check_word("reset out1", bus._out1, 32'd0);
    tb_reset = 1'b0;

    for (int k = 0; k < 9; k++) begin
      @(negedge tb_clock);
      bus._start    = vecs[k].start;
      bus._in_valid = vecs[k].in_valid;
      bus._in_done  = vecs[k].in_done;
      bus._ready    = vecs[k].ready;
      bus._in0      = vecs[k].in0;
      bus._in1      = vecs[k].in1;
      #1;
      check_bit($sformatf("vec%0d in_ready", k), bus._in_ready, vecs[k].exp_in_ready);
      check_bit($sformatf("vec%0d valid", k), bus._valid, vecs[k].exp_valid);
      check_bit($sformatf("vec%0d done", k), bus._done, vecs[k].exp_done);
      check_bit($sformatf("vec%0d in_start", k), bus._in_start, vecs[k].exp_in_start);
      if (vecs[k].exp_valid) begin
        check_word($sformatf("vec%0d out0", k), bus._out0, vecs[k].exp_out0);
        check_word($sformatf("vec%0d out1", k), bus._out1, vecs[k].exp_out1);
      end
    end

    // Back-pressure fills the buffer, then a single pop reopens it one cycle later.
    $display("[TB] back-pressure and full buffer");
    set_run(0, 10, 2);
    exp_list = '{0, 2, 4, 6, 8};
    ready_req = 1'b0;
    do_start();
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (up_fire) accepts++;
    end
    check_word("accepts before full", accepts, 4);
    check_bit("in_ready low when full", s_in_ready, 1'b0);
    check_word("full head out0", bus._out0, 32'd0);
    ready_req = 1'b1;
    applyStimulus();
    check_bit("in_ready low in pop cycle", s_in_ready, 1'b0);
    ready_req = 1'b0;
    applyStimulus();
    check_bit("in_ready reopens after pop", s_in_ready, 1'b1);
    check_bit("push of 8 accepted", up_fire, 1'b1);
    applyStimulus();
    check_bit("full again after refill", s_in_ready, 1'b0);
    checkOutput(40);

    // A start with traffic on both sides flushes and discards both transfers.
    $display("[TB] start mid-run");
    set_run(0, 10, 2);
    exp_list = '{0, 2, 4, 6, 8};
    ready_req = 1'b0;
    do_start();
    repeat (3) applyStimulus();
    ready_req = 1'b1;
    do_start();
    exp_idx = 0;
    applyStimulus();
    check_bit("flushed valid low", s_valid, 1'b0);
    check_bit("in_start after restart", s_in_start, 1'b1);
    checkOutput(40);

    // Reset with three tuples buffered; start while reset is held must be ignored.
    $display("[TB] reset mid-run");
    set_run(0, 10, 2);
    ready_req = 1'b0;
    do_start();
    repeat (4) applyStimulus();
    check_bit("three buffered valid", bus._valid, 1'b1);
    @(negedge tb_clock);
    tb_reset   = 1'b1;
    bus._start = 1'b1;
    #1;
    check_bit("async reset valid", bus._valid, 1'b0);
    check_bit("async reset done", bus._done, 1'b1);
    check_bit("async reset in_ready", bus._in_ready, 1'b0);
    check_word("async reset out0", bus._out0, 32'd0);
    @(posedge tb_clock);
    #1;
    check_bit("start under reset done", bus._done, 1'b1);
    check_bit("start under reset in_start", bus._in_start, 1'b0);
    @(negedge tb_clock);
    tb_reset   = 1'b0;
    bus._start = 1'b0;
    gen_active = 1'b0;
    applyStimulus();
    check_bit("idle after reset done", s_done, 1'b1);
    check_bit("idle after reset valid", s_valid, 1'b0);
    set_run(0, 10, 2);
    exp_list = '{0, 2, 4, 6, 8};
    ready_req = 1'b1;
    do_start();
    checkOutput(40);

    // Restart while the generator still reports done from the previous run.
    $display("[TB] restart with stale in_done");
    set_run(0, 10, 2);
    exp_list = '{0, 2, 4, 6, 8};
    ready_req = 1'b1;
    do_start();
    applyStimulus();
    check_bit("stale run in_start high", s_in_start, 1'b1);
    check_bit("stale run not done", s_done, 1'b0);
    applyStimulus();
    check_bit("in_start one cycle", s_in_start, 1'b0);
    check_bit("still RUN accepts", s_in_ready, 1'b1);
    checkOutput(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
